// File: rtl/sq_pkg.sv
// Shared store-queue types: access size, per-entry state and payload, plus
// byte-lane helpers used by both the queue and its load lookup.
package sq_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } MEM_SIZE;

  typedef enum logic [1:0] {
    SQ_FREE   = 2'd0,
    SQ_ALLOC  = 2'd1,
    SQ_EXEC   = 2'd2,
    SQ_COMMIT = 2'd3
  } SQ_STATE;

  typedef struct packed {
    SQ_STATE     state;
    logic [31:0] addr;
    logic [31:0] data;
    MEM_SIZE     size;
  } SQ_ENTRY;

  // Byte lanes touched within the aligned word.
  function automatic logic [3:0] byte_mask(input MEM_SIZE size, input logic [1:0] off);
    case (size)
      MEM_BYTE: byte_mask = 4'b0001 << off;
      MEM_HALF: byte_mask = 4'b0011 << {off[1], 1'b0};
      default:  byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input MEM_SIZE size, input logic [1:0] off);
    case (size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = off[0];
      MEM_WORD: misaligned = (off != 2'b00);
      default:  misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sq_fwd_lookup.sv
// Store-to-load forwarding for one load port: picks the youngest older store
// that is unresolved or overlaps the load, then forwards or requests a replay.
module sq_fwd_lookup
  import sq_pkg::*;
#(
  parameter  int unsigned N_SQ  = 8,
  localparam int unsigned IDX_W = $clog2(N_SQ) + 1
) (
  input  SQ_ENTRY [N_SQ-1:0] entries,
  input  logic [IDX_W-1:0]   head,
  input  logic               ld_valid,
  input  logic [31:0]        ld_addr,
  input  MEM_SIZE            ld_size,
  input  logic [IDX_W-1:0]   ld_sq_tail,
  output logic               fwd_valid,
  output logic [31:0]        fwd_data,
  output logic               stall
);

  localparam int unsigned PTR_W = $clog2(N_SQ);

  logic [IDX_W-1:0] span;
  logic [IDX_W-1:0] count;
  logic [3:0]       ld_mask;
  logic [3:0]       st_mask;
  logic             hit;
  logic [PTR_W-1:0] sel_slot;
  logic [31:0]      word;
  logic [31:0]      size_mask;

  function automatic logic qualifies(input SQ_ENTRY e, input logic [29:0] word_addr,
                                     input logic [3:0] mask);
    logic resolved;
    resolved = (e.state == SQ_EXEC) || (e.state == SQ_COMMIT);
    return (e.state == SQ_ALLOC) ||
           (resolved && (e.addr[31:2] == word_addr) &&
            ((byte_mask(e.size, e.addr[1:0]) & mask) != 4'b0000));
  endfunction

  always_comb begin
    fwd_valid = 1'b0;
    fwd_data  = '0;
    stall     = 1'b0;
    hit       = 1'b0;
    sel_slot  = '0;
    span      = ld_sq_tail - head;
    // A snapshot behind head means every older store has already drained.
    count     = (span > IDX_W'(N_SQ)) ? '0 : span;
    ld_mask   = byte_mask(ld_size, ld_addr[1:0]);

    // Oldest to youngest; the last qualifying entry is the youngest.
    for (int k = 0; k < N_SQ; k++) begin
      if ((IDX_W'(k) < count) &&
          qualifies(entries[PTR_W'(head[PTR_W-1:0] + PTR_W'(k))], ld_addr[31:2], ld_mask)) begin
        hit      = 1'b1;
        sel_slot = PTR_W'(head[PTR_W-1:0] + PTR_W'(k));
      end
    end

    st_mask = byte_mask(entries[sel_slot].size, entries[sel_slot].addr[1:0]);
    word    = entries[sel_slot].data << {entries[sel_slot].addr[1:0], 3'b000};
    word    = word >> {ld_addr[1:0], 3'b000};
    case (ld_size)
      MEM_BYTE: size_mask = 32'h0000_00FF;
      MEM_HALF: size_mask = 32'h0000_FFFF;
      default:  size_mask = 32'hFFFF_FFFF;
    endcase

    if (ld_valid && hit) begin
      if ((entries[sel_slot].state == SQ_ALLOC) || ((st_mask & ld_mask) != ld_mask)) begin
        stall = 1'b1;
      end else begin
        fwd_valid = 1'b1;
        fwd_data  = word & size_mask;
      end
    end
  end

endmodule

// File: rtl/store_queue_fwd.sv
// Circular store queue: in-order allocate, out-of-order execute capture,
// retire-driven commit, one-per-cycle dcache drain, and tail-rollback squash.
module store_queue_fwd
  import sq_pkg::*;
#(
  parameter  int unsigned N_WAY = 2,
  parameter  int unsigned N_SQ  = 8,
  parameter  int unsigned N_LD  = 2,
  parameter  int unsigned TAG_W = 6,
  localparam int unsigned IDX_W = $clog2(N_SQ) + 1,
  localparam int unsigned CNT_W = $clog2(N_WAY) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         dis_num,
  output logic [N_WAY*IDX_W-1:0]   dis_idx,
  output logic [CNT_W-1:0]         free_slots,
  output logic                     full,
  output logic                     empty,
  input  logic [N_WAY-1:0]         ex_valid,
  input  logic [N_WAY*IDX_W-1:0]   ex_idx,
  input  logic [N_WAY*32-1:0]      ex_addr,
  input  logic [N_WAY*32-1:0]      ex_data,
  input  logic [N_WAY*2-1:0]       ex_size,
  input  logic [CNT_W-1:0]         ret_num,
  input  logic [N_LD-1:0]          ld_valid,
  input  logic [N_LD*32-1:0]       ld_addr,
  input  logic [N_LD*2-1:0]        ld_size,
  input  logic [N_LD*IDX_W-1:0]    ld_sq_tail,
  input  logic [N_LD*TAG_W-1:0]    ld_tag,
  output logic [N_LD-1:0]          ld_fwd_valid,
  output logic [N_LD*32-1:0]       ld_fwd_data,
  output logic [N_LD*TAG_W-1:0]    ld_fwd_tag,
  output logic [N_LD-1:0]          ld_stall,
  output logic                     dc_req_valid,
  output logic [31:0]              dc_req_addr,
  output logic [31:0]              dc_req_data,
  output logic [1:0]               dc_req_size,
  input  logic                     dc_req_ready,
  input  logic                     squash,
  input  logic [IDX_W-1:0]         squash_tail
);

  localparam int unsigned PTR_W = $clog2(N_SQ);

  SQ_ENTRY [N_SQ-1:0] entries;
  SQ_ENTRY [N_SQ-1:0] entries_nxt;
  SQ_ENTRY            head_entry;
  logic [IDX_W-1:0]   head, head_nxt;
  logic [IDX_W-1:0]   commit_ptr, commit_nxt;
  logic [IDX_W-1:0]   tail, tail_nxt;
  logic [IDX_W-1:0]   occupancy, free_cnt, sq_len;
  logic [PTR_W-1:0]   ex_slot [N_WAY];
  logic [N_WAY-1:0]   ex_live;
  logic               drain;
  logic               ret_ok, ex_ok, ld_ok;

  assign occupancy  = tail - head;
  assign free_cnt   = IDX_W'(N_SQ) - occupancy;
  assign full       = (tail[PTR_W-1:0] == head[PTR_W-1:0]) && (tail[PTR_W] != head[PTR_W]);
  assign empty      = (tail == head);
  assign free_slots = (free_cnt < IDX_W'(N_WAY)) ? CNT_W'(free_cnt) : CNT_W'(N_WAY);

  assign head_entry   = entries[head[PTR_W-1:0]];
  assign dc_req_valid = (head_entry.state == SQ_COMMIT);
  assign dc_req_addr  = head_entry.addr;
  assign dc_req_data  = head_entry.data;
  assign dc_req_size  = head_entry.size;
  assign drain        = dc_req_valid && dc_req_ready;

  // The wrap bit rejects late execute results aimed at a recycled slot.
  for (genvar i = 0; i < N_WAY; i++) begin : g_way
    logic [IDX_W-1:0] ex_off;
    assign dis_idx[i*IDX_W +: IDX_W] = tail + IDX_W'(i);
    assign ex_off     = ex_idx[i*IDX_W +: IDX_W] - head;
    assign ex_slot[i] = ex_idx[i*IDX_W +: PTR_W];
    assign ex_live[i] = (ex_off < occupancy);
  end

  // Next state; squash is applied last so it overrides same-cycle execute writes.
  always_comb begin
    entries_nxt = entries;
    head_nxt    = head;
    commit_nxt  = commit_ptr;
    tail_nxt    = tail;
    sq_len      = tail - squash_tail;

    if (!squash) begin
      for (int i = 0; i < N_WAY; i++) begin
        if (CNT_W'(i) < dis_num)
          entries_nxt[PTR_W'(tail[PTR_W-1:0] + PTR_W'(i))].state = SQ_ALLOC;
      end
      tail_nxt = tail + IDX_W'(dis_num);
    end

    for (int i = 0; i < N_WAY; i++) begin
      if (ex_valid[i] && ex_live[i] && (entries[ex_slot[i]].state == SQ_ALLOC)) begin
        entries_nxt[ex_slot[i]] = '{state: SQ_EXEC,
                                    addr:  ex_addr[i*32 +: 32],
                                    data:  ex_data[i*32 +: 32],
                                    size:  MEM_SIZE'(ex_size[i*2 +: 2])};
      end
    end

    for (int i = 0; i < N_WAY; i++) begin
      if (CNT_W'(i) < ret_num)
        entries_nxt[PTR_W'(commit_ptr[PTR_W-1:0] + PTR_W'(i))].state = SQ_COMMIT;
    end
    commit_nxt = commit_ptr + IDX_W'(ret_num);

    if (drain) begin
      entries_nxt[head[PTR_W-1:0]].state = SQ_FREE;
      head_nxt = head + IDX_W'(1);
    end

    if (squash) begin
      for (int j = 0; j < N_SQ; j++) begin
        if (IDX_W'(PTR_W'(PTR_W'(j) - squash_tail[PTR_W-1:0])) < sq_len)
          entries_nxt[j].state = SQ_FREE;
      end
      tail_nxt = squash_tail;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries    <= '0;
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
    end else begin
      entries    <= entries_nxt;
      head       <= head_nxt;
      commit_ptr <= commit_nxt;
      tail       <= tail_nxt;
    end
  end

  for (genvar p = 0; p < N_LD; p++) begin : g_ld
    sq_fwd_lookup #(.N_SQ(N_SQ)) u_lookup (
      .entries    (entries),
      .head       (head),
      .ld_valid   (ld_valid[p]),
      .ld_addr    (ld_addr[p*32 +: 32]),
      .ld_size    (MEM_SIZE'(ld_size[p*2 +: 2])),
      .ld_sq_tail (ld_sq_tail[p*IDX_W +: IDX_W]),
      .fwd_valid  (ld_fwd_valid[p]),
      .fwd_data   (ld_fwd_data[p*32 +: 32]),
      .stall      (ld_stall[p])
    );
  end

  assign ld_fwd_tag = ld_tag;

  // Upstream contract checks.
  always_comb begin
    ret_ok = 1'b1;
    ex_ok  = 1'b1;
    ld_ok  = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      if ((CNT_W'(i) < ret_num) &&
          (entries[PTR_W'(commit_ptr[PTR_W-1:0] + PTR_W'(i))].state != SQ_EXEC))
        ret_ok = 1'b0;
      if (ex_valid[i] && misaligned(MEM_SIZE'(ex_size[i*2 +: 2]), ex_addr[i*32 +: 2]))
        ex_ok = 1'b0;
    end
    for (int p = 0; p < N_LD; p++) begin
      if (ld_valid[p] && misaligned(MEM_SIZE'(ld_size[p*2 +: 2]), ld_addr[p*32 +: 2]))
        ld_ok = 1'b0;
    end
  end

  a_dis_fit:  assert property (@(posedge clock) disable iff (!reset) squash || (dis_num <= free_slots));
  a_ret_exec: assert property (@(posedge clock) disable iff (!reset) ret_ok);
  a_ex_align: assert property (@(posedge clock) disable iff (!reset) ex_ok);
  a_ld_align: assert property (@(posedge clock) disable iff (!reset) ld_ok);

endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd: allocation/wrap, forwarding, stalls,
// squash recovery and dcache drain, with hand-computed expectations.
module tb_store_queue_fwd;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic        clock, reset;
  logic [1:0]  dis_num;
  logic [7:0]  dis_idx;
  logic [1:0]  free_slots;
  logic        full, empty;
  logic [1:0]  ex_valid;
  logic [7:0]  ex_idx;
  logic [63:0] ex_addr, ex_data;
  logic [3:0]  ex_size;
  logic [1:0]  ret_num;
  logic [1:0]  ld_valid;
  logic [63:0] ld_addr;
  logic [3:0]  ld_size;
  logic [7:0]  ld_sq_tail;
  logic [11:0] ld_tag;
  logic [1:0]  ld_fwd_valid;
  logic [63:0] ld_fwd_data;
  logic [11:0] ld_fwd_tag;
  logic [1:0]  ld_stall;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr, dc_req_data;
  logic [1:0]  dc_req_size;
  logic        dc_req_ready;
  logic        squash;
  logic [3:0]  squash_tail;

  int total = 0;
  int bad   = 0;

  store_queue_fwd dut (
    .clock(clock), .reset(reset),
    .dis_num(dis_num), .dis_idx(dis_idx), .free_slots(free_slots), .full(full), .empty(empty),
    .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_addr(ex_addr), .ex_data(ex_data), .ex_size(ex_size),
    .ret_num(ret_num),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_sq_tail(ld_sq_tail), .ld_tag(ld_tag),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .ld_fwd_tag(ld_fwd_tag), .ld_stall(ld_stall),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .dc_req_size(dc_req_size), .dc_req_ready(dc_req_ready),
    .squash(squash), .squash_tail(squash_tail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dis_num = '0; ex_valid = '0; ex_idx = '0; ex_addr = '0; ex_data = '0; ex_size = '0;
    ret_num = '0; ld_valid = '0; ld_addr = '0; ld_size = '0; ld_sq_tail = '0; ld_tag = '0;
    dc_req_ready = 1'b0; squash = 1'b0; squash_tail = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_ex(input int p, input logic [3:0] idx, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] size);
    ex_valid[p]          = 1'b1;
    ex_idx[p*4 +: 4]     = idx;
    ex_addr[p*32 +: 32]  = addr;
    ex_data[p*32 +: 32]  = data;
    ex_size[p*2 +: 2]    = size;
  endtask

  task automatic set_ld(input int p, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] snap, input logic [5:0] tag);
    ld_valid[p]           = 1'b1;
    ld_addr[p*32 +: 32]   = addr;
    ld_size[p*2 +: 2]     = size;
    ld_sq_tail[p*4 +: 4]  = snap;
    ld_tag[p*6 +: 6]      = tag;
  endtask

  task automatic chk_ld(input string tag, input int p, input logic v, input logic s,
                        input logic [31:0] d);
    check({tag, "_fwd_valid"}, 32'(ld_fwd_valid[p]), 32'(v));
    check({tag, "_stall"}, 32'(ld_stall[p]), 32'(s));
    check({tag, "_data"}, ld_fwd_data[p*32 +: 32], d);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_dc_valid", 32'(dc_req_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_free_slots", 32'(free_slots), 32'd2);
    check("rst_fwd_valid", 32'(ld_fwd_valid), 32'd0);
    check("rst_stall", 32'(ld_stall), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Fill the queue, then drain one entry and reallocate across the wrap.
    for (int c = 0; c < 4; c++) begin
      dis_num = 2'd2;
      #1;
      check("dis_idx0", 32'(dis_idx[3:0]), 32'(4'(2*c)));
      check("dis_idx1", 32'(dis_idx[7:4]), 32'(4'(2*c+1)));
      tick();
    end
    dis_num = '0;
    #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_free_slots", 32'(free_slots), 32'd0);
    check("fill_empty", 32'(empty), 32'd0);
    check("fill_dis_idx0", 32'(dis_idx[3:0]), 32'd8);
    set_ex(0, 4'd0, 32'h3000, 32'h1234_5678, SZ_W);
    tick();
    ex_valid = '0;
    ret_num = 2'd1;
    tick();
    ret_num = '0;
    dc_req_ready = 1'b1;
    #1;
    check("wrap_dc_valid", 32'(dc_req_valid), 32'd1);
    check("wrap_dc_addr", dc_req_addr, 32'h3000);
    check("wrap_dc_data", dc_req_data, 32'h1234_5678);
    check("wrap_dc_size", 32'(dc_req_size), 32'(SZ_W));
    check("drain_cycle_full", 32'(full), 32'd1);
    check("drain_cycle_free", 32'(free_slots), 32'd0);
    tick();
    dc_req_ready = 1'b0;
    #1;
    check("post_drain_full", 32'(full), 32'd0);
    check("post_drain_free", 32'(free_slots), 32'd1);
    check("post_drain_idx", 32'(dis_idx[3:0]), 32'd8);
    check("post_drain_dc_valid", 32'(dc_req_valid), 32'd0);
    dis_num = 2'd1;
    tick();
    dis_num = '0;
    #1;
    check("refill_full", 32'(full), 32'd1);

    // Word store forwarded to narrower younger loads.
    do_reset();
    dis_num = 2'd2;
    tick();
    dis_num = '0;
    set_ex(0, 4'd0, 32'h1000, 32'hAABB_CCDD, SZ_W);
    tick();
    ex_valid = '0;
    set_ld(0, 32'h1002, SZ_B, 4'd1, 6'd5);
    set_ld(1, 32'h1002, SZ_H, 4'd1, 6'd9);
    #1;
    chk_ld("ld_byte", 0, 1'b1, 1'b0, 32'h0000_00BB);
    chk_ld("ld_half", 1, 1'b1, 1'b0, 32'h0000_AABB);
    check("ld_tag0", 32'(ld_fwd_tag[5:0]), 32'd5);
    check("ld_tag1", 32'(ld_fwd_tag[11:6]), 32'd9);
    set_ld(0, 32'h1004, SZ_W, 4'd1, 6'd3);
    ld_valid[1] = 1'b0;
    #1;
    chk_ld("ld_nomatch", 0, 1'b0, 1'b0, 32'h0);
    chk_ld("ld_idle", 1, 1'b0, 1'b0, 32'h0);

    // Unresolved and partially overlapping older stores force a replay.
    set_ld(0, 32'h1000, SZ_W, 4'd2, 6'd1);
    #1;
    chk_ld("ld_alloc", 0, 1'b0, 1'b1, 32'h0);
    ld_valid = '0;
    set_ex(0, 4'd1, 32'h1001, 32'h0000_0011, SZ_B);
    tick();
    ex_valid = '0;
    set_ld(0, 32'h1000, SZ_W, 4'd2, 6'd1);
    set_ld(1, 32'h1001, SZ_B, 4'd2, 6'd2);
    #1;
    chk_ld("ld_partial", 0, 1'b0, 1'b1, 32'h0);
    chk_ld("ld_byte_fwd", 1, 1'b1, 1'b0, 32'h0000_0011);
    set_ld(0, 32'h1000, SZ_B, 4'd2, 6'd1);
    ld_valid[1] = 1'b0;
    #1;
    chk_ld("ld_skip_young", 0, 1'b1, 1'b0, 32'h0000_00DD);
    ld_valid = '0;

    // Squash to index 3 with two committed entries, then drain with backpressure.
    do_reset();
    dis_num = 2'd2;
    tick();
    tick();
    tick();
    dis_num = '0;
    set_ex(0, 4'd0, 32'h4000, 32'h0A0A_0A0A, SZ_W);
    set_ex(1, 4'd1, 32'h4006, 32'h0000_BEEF, SZ_H);
    tick();
    set_ex(0, 4'd2, 32'h6000, 32'h6666_6666, SZ_W);
    set_ex(1, 4'd3, 32'h5000, 32'h3333_3333, SZ_W);
    tick();
    ex_valid = '0;
    ret_num = 2'd2;
    set_ld(0, 32'h5000, SZ_W, 4'd4, 6'd7);
    #1;
    chk_ld("ld_pre_squash", 0, 1'b1, 1'b0, 32'h3333_3333);
    ld_valid = '0;
    tick();
    ret_num = '0;
    squash = 1'b1;
    squash_tail = 4'd3;
    dis_num = 2'd1;
    #1;
    check("sq_dc_valid", 32'(dc_req_valid), 32'd1);
    check("sq_dc_addr", dc_req_addr, 32'h4000);
    tick();
    squash = 1'b0;
    dis_num = '0;
    #1;
    check("sq_free_slots", 32'(free_slots), 32'd2);
    check("sq_dis_idx0", 32'(dis_idx[3:0]), 32'd3);
    check("sq_full", 32'(full), 32'd0);
    check("sq_empty", 32'(empty), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("hold_valid", 32'(dc_req_valid), 32'd1);
      check("hold_addr", dc_req_addr, 32'h4000);
      check("hold_data", dc_req_data, 32'h0A0A_0A0A);
      tick();
    end
    dc_req_ready = 1'b1;
    #1;
    check("drain0_addr", dc_req_addr, 32'h4000);
    tick();
    check("drain1_valid", 32'(dc_req_valid), 32'd1);
    check("drain1_addr", dc_req_addr, 32'h4006);
    check("drain1_data", dc_req_data, 32'h0000_BEEF);
    check("drain1_size", 32'(dc_req_size), 32'(SZ_H));
    tick();
    dc_req_ready = 1'b0;
    #1;
    check("drain_done_valid", 32'(dc_req_valid), 32'd0);
    set_ld(0, 32'h5000, SZ_W, 4'd6, 6'd1);
    set_ld(1, 32'h6000, SZ_W, 4'd3, 6'd2);
    #1;
    chk_ld("ld_squashed", 0, 1'b0, 1'b0, 32'h0);
    chk_ld("ld_survivor", 1, 1'b1, 1'b0, 32'h6666_6666);
    ld_valid = '0;

    // Same-address stores: the snapshot decides which one is visible.
    do_reset();
    dis_num = 2'd2;
    tick();
    dis_num = '0;
    set_ex(0, 4'd0, 32'h2000, 32'd1, SZ_W);
    set_ex(1, 4'd1, 32'h2000, 32'd2, SZ_W);
    tick();
    ex_valid = '0;
    set_ld(0, 32'h2000, SZ_W, 4'd2, 6'd1);
    set_ld(1, 32'h2000, SZ_W, 4'd1, 6'd2);
    #1;
    chk_ld("ld_youngest", 0, 1'b1, 1'b0, 32'd2);
    chk_ld("ld_older", 1, 1'b1, 1'b0, 32'd1);
    set_ld(1, 32'h2000, SZ_W, 4'd0, 6'd2);
    #1;
    chk_ld("ld_none_older", 1, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset while a drain request is pending.
    ret_num = 2'd2;
    tick();
    ret_num = '0;
    #1;
    check("pre_rst_dc_valid", 32'(dc_req_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dc_valid", 32'(dc_req_valid), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_free", 32'(free_slots), 32'd2);
    check("mid_rst_fwd", 32'(ld_fwd_valid[0]), 32'd0);
    tick();
    idle();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
